shift_unit: RTL
===============

# shift_unit

Parametrised multi-cycle shifter for the MIPS datapath. It is the successor to the fixed shift-by-2 offset block. It performs logical left, logical right, arithmetic right and rotate-right by a runtime amount, advancing at most STEP bit positions per clock. It sits beside the ALU and serves sll/srl/sra/sllv/srlv/srav-class instructions through a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 32, data width in bits; power of 2, ≥ 4.
- STEP, 2, maximum bit positions shifted per cycle; power of 2, 1 ≤ STEP ≤ WIDTH.
- SHAMT_W, $clog2(WIDTH), derived localparam; not overridable.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is accepting.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- din  in  WIDTH  operand.
- busy  out  1  high while a shift is in progress (SHIFT state).
- done  out  1  one-cycle pulse; dout holds the new result.
- dout  out  WIDTH  result register; held until the next completion.

## Operation
- States:
  - IDLE: accepting.
  - SHIFT: stepping.
  - DONE: result pulse; also accepting.
- Accepting (IDLE or DONE) with start=1:
  - Capture din into the working register, op into the op register, and shamt into the remaining counter.
  - Go to DONE if shamt==0; otherwise go to SHIFT.
- SHIFT, each cycle:
  - k = min(STEP, remaining).
  - Working register is shifted by k according to op. SLL and SRL fill with 0. SRA fills with the captured MSB. ROR wraps the low bits to the top.
  - remaining -= k.
  - Go to DONE when remaining becomes 0.
- start is ignored in SHIFT. Inputs are not re-sampled mid-operation.
- Entry to DONE: dout <= final working value; done=1 for exactly that cycle.
- DONE with start=0 → IDLE. DONE with start=1 → new operation, back-to-back.
- Reset outputs: busy=0, done=0, dout=0. State is IDLE and remaining=0.
- rst mid-operation: abort immediately. No done pulse; dout reset to 0.
- rst has priority over start in the same cycle.

## Timing
- start accepted at edge T ⇒ done high in cycle T+1+ceil(shamt/STEP).
- shamt=0 ⇒ done at T+1 with dout=din.
- busy is high for exactly ceil(shamt/STEP) cycles, starting at T+1.
- Worst case, shamt=WIDTH-1: latency 1+ceil((WIDTH-1)/STEP). With the defaults this is 17 cycles.
- Back-to-back: a start in the done cycle yields the next done after the same latency formula. There is no idle bubble.
- dout and done are registered outputs. busy is decoded from the state register.

## Structure
- Package shift_pkg holds:
  - op encoding constants: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11.
  - the FSM state encoding: IDLE, SHIFT, DONE.
- Sub-module shift_step: combinational shift of WIDTH bits by 0..STEP per op. It is instantiated once and fed the working register and k.
- Top holds the FSM, the working register, the remaining counter (SHAMT_W bits), the op register and the dout register.

## Test plan
Defaults apply (WIDTH=32, STEP=2).
- SLL, din=0x00000002, shamt=2 → dout=0x00000008, done at T+2, busy for 1 cycle.
- SRA, din=0xF0F0F0F0, shamt=4 → dout=0xFF0F0F0F at T+3.
- ROR, din=0x12341234, shamt=8 → dout=0x34123412 at T+5.
- SRL, din=0xFFFFFFFF, shamt=31 → dout=0x00000001 at T+17.
- shamt=0 (any op), din=0xA5A5A5A5 → dout=0xA5A5A5A5 at T+1.
- Second start pulsed while busy is ignored; result matches the first request.
- Back-to-back start in the done cycle is honoured.
- rst asserted mid-SHIFT → next cycle busy=0, done=0, dout=0, and no done pulse follows.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encoding and FSM state type for shift_unit
// Contents:
//   OP_SLL/OP_SRL/OP_SRA/OP_ROR : 2-bit operation codes on the op port
//   state_t                     : IDLE (accepting), SHIFT (stepping), DONE (result pulse, accepting)
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift of one word by 0..STEP positions
// Ports:
//   data   in  WIDTH  word to shift
//   op     in  2      operation (shift_pkg OP_* codes)
//   k      in  KW     shift distance for this step, 0..STEP
//   result out WIDTH  shifted word
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] result
);

  // Doubled word: shifting right and keeping the low half gives a rotate,
  // and stays correct even when k equals WIDTH.
  logic [2*WIDTH-1:0] doubled;

  always_comb begin
    result  = data;
    doubled = {data, data} >> k;
    case (op)
      OP_SLL: result = data << k;
      OP_SRL: result = data >> k;
      // The working MSB always equals the captured MSB, since every
      // earlier SRA step preserved it.
      OP_SRA: result = $unsigned($signed(data) >>> k);
      OP_ROR: result = doubled[WIDTH-1:0];
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle shifter, at most STEP bit positions per clock
// Ports:
//   clk   in  1        rising-edge clock
//   rst   in  1        synchronous active-high reset
//   start in  1        request, sampled in IDLE or DONE only
//   op    in  2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//   shamt in  SHAMT_W  shift amount 0..WIDTH-1
//   din   in  WIDTH    operand
//   busy  out 1        high while in SHIFT
//   done  out 1        one-cycle pulse when dout is updated
//   dout  out WIDTH    result, held until the next completion
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  localparam int KW = $clog2(STEP + 1);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] remaining;
  logic [KW-1:0]      k;
  logic               last_step;
  logic [WIDTH-1:0]   step_out;

  // Compare one bit wider so STEP == WIDTH does not overflow SHAMT_W.
  always_comb begin
    last_step = ({1'b0, remaining} <= (SHAMT_W + 1)'(STEP));
    k         = KW'(STEP);
    if (last_step) k = KW'(remaining);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .data   (work),
    .op     (op_q),
    .k      (k),
    .result (step_out)
  );

  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      op_q      <= OP_SLL;
      remaining <= '0;
      dout      <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work      <= din;
            op_q      <= op;
            remaining <= shamt;
            if (shamt == '0) begin
              state <= DONE;
              dout  <= din;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work      <= step_out;
          remaining <= remaining - SHAMT_W'(k);
          if (last_step) begin
            state <= DONE;
            dout  <= step_out;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
